core_pipe_ctrl: RTL and testbench

- Pipeline sequencer for the IF / IF_ID / ID / EX path of the xRV32I core.
- Owns the PC and drives the instruction-fetch request.
- Generates per-stage hold and flush controls, resolving jump requests from EX, multi-cycle hold requests from EX, and fetch-bus wait states.
- Sits beside core_if_id and core_ex; the decode stage consumes whatever IF_ID presents under these controls.

---
 rtl/core_pipe_ctrl.sv | 158 +++++++++++++++
 tb/tb_core_pipe_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/core_pipe_ctrl.sv
// core_pipe_ctrl: PC owner and pipeline sequencer for the IF / IF_ID / ID / EX
// path. It resolves EX jumps, EX multi-cycle holds and fetch-bus wait states
// into per-stage hold and flush controls.
// Optional build macro: CTRL_PERF_CNT_EN adds cycle, stall and flush counters.
module core_pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        jump_en_in,
    input  logic [31:0] jump_addr_in,
    input  logic        hold_ex_in,
    input  logic        fetch_ack_in,
    output logic        fetch_req_out,
    output logic [31:0] pc_out,
    output logic [2:0]  hold_flag_out,
    output logic        flush_if_id_out,
    output logic        flush_id_ex_out,
    output logic [2:0]  state_out
`ifdef CTRL_PERF_CNT_EN
    ,
    output logic [31:0] perf_cycle_out,
    output logic [31:0] perf_stall_out,
    output logic [31:0] perf_flush_out
`endif
);

    localparam logic [2:0] ST_BOOT       = 3'd0;
    localparam logic [2:0] ST_RUN        = 3'd1;
    localparam logic [2:0] ST_HOLD_EX    = 3'd2;
    localparam logic [2:0] ST_FETCH_WAIT = 3'd3;
    localparam logic [2:0] ST_JUMP_PEND  = 3'd4;

    logic [2:0]  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] pend_addr_q, pend_addr_d;
    logic        pend_valid_q, pend_valid_d;
    logic [31:0] jump_tgt;

    // Masking keeps the target word aligned whatever EX presents in bits [1:0].
    assign jump_tgt = jump_addr_in & 32'hFFFF_FFFC;

    // Next-state and control decode; priority is jump > hold_ex > stall > advance.
    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        pend_addr_d     = pend_addr_q;
        pend_valid_d    = pend_valid_q;
        fetch_req_out   = 1'b1;
        hold_flag_out   = 3'b000;
        flush_if_id_out = 1'b0;
        flush_id_ex_out = 1'b0;

        if (state_q == ST_BOOT) begin
            // Single settling cycle after reset: everything held and flushed.
            fetch_req_out   = 1'b0;
            hold_flag_out   = 3'b111;
            flush_if_id_out = 1'b1;
            flush_id_ex_out = 1'b1;
            state_d         = ST_RUN;
        end else if (jump_en_in) begin
            flush_if_id_out = 1'b1;
            flush_id_ex_out = 1'b1;
            if (fetch_ack_in) begin
                pc_d         = jump_tgt;
                pend_valid_d = 1'b0;
                state_d      = ST_RUN;
            end else begin
                // Fetch in flight: pc must stay stable until the bus answers,
                // so park the target (a later jump overwrites it).
                pend_addr_d  = jump_tgt;
                pend_valid_d = 1'b1;
                state_d      = ST_JUMP_PEND;
            end
        end else if (state_q == ST_JUMP_PEND) begin
            // Wrong-path data is still coming back; bubble it out of IF_ID.
            hold_flag_out   = 3'b001;
            flush_if_id_out = 1'b1;
            if (fetch_ack_in) begin
                if (pend_valid_q) begin
                    pc_d = pend_addr_q;
                end
                pend_valid_d = 1'b0;
                state_d      = ST_RUN;
            end
        end else if (hold_ex_in) begin
            // Any ack during the hold is dropped; same pc is refetched later.
            hold_flag_out = 3'b111;
            state_d       = ST_HOLD_EX;
        end else if (!fetch_ack_in) begin
            hold_flag_out   = 3'b001;
            flush_if_id_out = 1'b1;
            state_d         = ST_FETCH_WAIT;
        end else begin
            pc_d    = pc_q + PC_STEP;
            state_d = ST_RUN;
        end
    end

    // Sequencer registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_BOOT;
            pc_q         <= RESET_PC;
            pend_addr_q  <= 32'h0;
            pend_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            pend_addr_q  <= pend_addr_d;
            pend_valid_q <= pend_valid_d;
        end
    end

    assign pc_out    = pc_q;
    assign state_out = state_q;

`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_cycle_q, perf_cycle_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Counter increments; BOOT cycles are not counted.
    always_comb begin
        perf_cycle_d = perf_cycle_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (state_q != ST_BOOT) begin
            perf_cycle_d = perf_cycle_q + 32'd1;
            if (hold_flag_out != 3'b000) begin
                perf_stall_d = perf_stall_q + 32'd1;
            end
            if (jump_en_in) begin
                perf_flush_d = perf_flush_q + 32'd1;
            end
        end
    end

    // Counter registers, cleared by reset and free-wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            perf_cycle_q <= 32'h0;
            perf_stall_q <= 32'h0;
            perf_flush_q <= 32'h0;
        end else begin
            perf_cycle_q <= perf_cycle_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_cycle_out = perf_cycle_q;
    assign perf_stall_out = perf_stall_q;
    assign perf_flush_out = perf_flush_q;
`endif

endmodule

// File: tb/tb_core_pipe_ctrl.sv
// Testbench for core_pipe_ctrl: directed vector table, async reset mid-stall,
// then randomized cycles checked against a rule-level reference model.
module tb_core_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        jump_en_in;
    logic [31:0] jump_addr_in;
    logic        hold_ex_in;
    logic        fetch_ack_in;
    logic        fetch_req_out;
    logic [31:0] pc_out;
    logic [2:0]  hold_flag_out;
    logic        flush_if_id_out;
    logic        flush_id_ex_out;
    logic [2:0]  state_out;
`ifdef CTRL_PERF_CNT_EN
    logic [31:0] perf_cycle_out, perf_stall_out, perf_flush_out;
`endif

    int errors = 0;
    int checks = 0;

    core_pipe_ctrl dut (
        .clk             (clk),
        .rst             (rst),
        .jump_en_in      (jump_en_in),
        .jump_addr_in    (jump_addr_in),
        .hold_ex_in      (hold_ex_in),
        .fetch_ack_in    (fetch_ack_in),
        .fetch_req_out   (fetch_req_out),
        .pc_out          (pc_out),
        .hold_flag_out   (hold_flag_out),
        .flush_if_id_out (flush_if_id_out),
        .flush_id_ex_out (flush_id_ex_out),
        .state_out       (state_out)
`ifdef CTRL_PERF_CNT_EN
        ,
        .perf_cycle_out  (perf_cycle_out),
        .perf_stall_out  (perf_stall_out),
        .perf_flush_out  (perf_flush_out)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: the pipeline viewed as "booting", "jump pending" and a pc.
    bit          m_boot;
    bit          m_pend;
    logic [31:0] m_tgt;
    logic [31:0] m_pc;
    int          m_mode;   // state number the last cycle's outcome selected
    logic [31:0] m_cyc, m_stl, m_fls;

    logic        e_req, e_fi, e_fe;
    logic [31:0] e_pc;
    logic [2:0]  e_hold, e_st;
    logic [31:0] e_cyc, e_stl, e_fls;

    typedef struct {
        logic        j;
        logic [31:0] a;
        logic        h;
        logic        k;
        logic [31:0] pc;
        logic [2:0]  hf;
        logic        fi;
        logic        fe;
        logic [2:0]  st;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1'b1; m_pend = 1'b0; m_tgt = 32'h0; m_pc = 32'h0; m_mode = 0;
        m_cyc = 32'h0; m_stl = 32'h0; m_fls = 32'h0;
    endtask

    // Produce expected outputs for this cycle's inputs and advance the model.
    task automatic model_step(input logic j, input logic [31:0] a, input logic h, input logic k);
        e_pc  = m_pc;
        e_st  = 3'(m_mode);
        e_cyc = m_cyc; e_stl = m_stl; e_fls = m_fls;
        if (m_boot) begin
            e_req = 0; e_hold = 3'b111; e_fi = 1; e_fe = 1;
            m_boot = 0; m_mode = 1;
        end else begin
            e_req = 1; e_hold = 3'b000; e_fi = 0; e_fe = 0;
            if (j) begin
                e_fi = 1; e_fe = 1;
                if (k) begin m_pc = {a[31:2], 2'b00}; m_pend = 0; m_mode = 1; end
                else   begin m_tgt = {a[31:2], 2'b00}; m_pend = 1; m_mode = 4; end
            end else if (m_pend) begin
                e_hold = 3'b001; e_fi = 1;
                if (k) begin m_pc = m_tgt; m_pend = 0; m_mode = 1; end
            end else if (h) begin
                e_hold = 3'b111; m_mode = 2;
            end else if (!k) begin
                e_hold = 3'b001; e_fi = 1; m_mode = 3;
            end else begin
                m_pc = m_pc + 32'd4; m_mode = 1;
            end
            m_cyc = m_cyc + 1;
            if (e_hold != 0) m_stl = m_stl + 1;
            if (j) m_fls = m_fls + 1;
        end
    endtask

    // Drive one cycle of inputs, then sample on the falling edge.
    task automatic apply(input logic j, input logic [31:0] a, input logic h, input logic k);
        jump_en_in = j; jump_addr_in = a; hold_ex_in = h; fetch_ack_in = k;
        @(negedge clk);
        model_step(j, a, h, k);
    endtask

    task automatic next_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model(input int n);
        chk("req", 32'(fetch_req_out), 32'(e_req));
        chk("pc", pc_out, e_pc);
        chk("hold", 32'(hold_flag_out), 32'(e_hold));
        chk("flush_if_id", 32'(flush_if_id_out), 32'(e_fi));
        chk("flush_id_ex", 32'(flush_id_ex_out), 32'(e_fe));
        chk("state", 32'(state_out), 32'(e_st));
`ifdef CTRL_PERF_CNT_EN
        chk("perf_cycle", perf_cycle_out, e_cyc);
        chk("perf_stall", perf_stall_out, e_stl);
        chk("perf_flush", perf_flush_out, e_fls);
`endif
        $display("cyc %0d j=%0d a=%h h=%0d k=%0d -> pc=%h hold=%b fl=%0d%0d st=%0d",
                 n, jump_en_in, jump_addr_in, hold_ex_in, fetch_ack_in,
                 pc_out, hold_flag_out, flush_if_id_out, flush_id_ex_out, state_out);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_req"}, 32'(fetch_req_out), 32'h0);
        chk({tag, "_pc"}, pc_out, 32'h0);
        chk({tag, "_hold"}, 32'(hold_flag_out), 32'h7);
        chk({tag, "_flush_if_id"}, 32'(flush_if_id_out), 32'h1);
        chk({tag, "_flush_id_ex"}, 32'(flush_id_ex_out), 32'h1);
        chk({tag, "_state"}, 32'(state_out), 32'h0);
    endtask

    initial begin
        //          j  addr          h  k  pc            hf  fi fe st
        tbl[0]  = '{0, 32'h0,        0, 1, 32'h0,        7,  1, 1, 0};
        tbl[1]  = '{0, 32'h0,        0, 1, 32'h0,        0,  0, 0, 1};
        tbl[2]  = '{0, 32'h0,        0, 1, 32'h4,        0,  0, 0, 1};
        tbl[3]  = '{1, 32'h103,      0, 1, 32'h8,        0,  1, 1, 1};
        tbl[4]  = '{1, 32'h8,        0, 1, 32'h100,      0,  1, 1, 1};
        tbl[5]  = '{1, 32'h200,      0, 0, 32'h8,        0,  1, 1, 1};
        tbl[6]  = '{1, 32'h300,      0, 0, 32'h8,        0,  1, 1, 4};
        tbl[7]  = '{0, 32'h0,        0, 1, 32'h8,        1,  1, 0, 4};
        tbl[8]  = '{1, 32'h10,       0, 1, 32'h300,      0,  1, 1, 1};
        tbl[9]  = '{0, 32'h0,        1, 1, 32'h10,       7,  0, 0, 1};
        tbl[10] = '{0, 32'h0,        1, 1, 32'h10,       7,  0, 0, 2};
        tbl[11] = '{0, 32'h0,        1, 1, 32'h10,       7,  0, 0, 2};
        tbl[12] = '{0, 32'h0,        0, 1, 32'h10,       0,  0, 0, 2};
        tbl[13] = '{1, 32'h20,       0, 1, 32'h14,       0,  1, 1, 1};
        tbl[14] = '{0, 32'h0,        0, 0, 32'h20,       1,  1, 0, 1};
        tbl[15] = '{0, 32'h0,        0, 0, 32'h20,       1,  1, 0, 3};
        tbl[16] = '{0, 32'h0,        0, 1, 32'h20,       0,  0, 0, 3};
        tbl[17] = '{1, 32'hFFFF_FFFF, 0, 1, 32'h24,      0,  1, 1, 1};
        tbl[18] = '{0, 32'h0,        0, 1, 32'hFFFF_FFFC, 0, 0, 0, 1};
        tbl[19] = '{0, 32'h0,        0, 1, 32'h0,        0,  0, 0, 1};

        rst = 1'b0; jump_en_in = 0; jump_addr_in = 0; hold_ex_in = 0; fetch_ack_in = 0;
        #3;
        check_reset_vals("reset");
        next_edge();
        next_edge();
        model_reset();
        rst = 1'b1;

        // Directed vectors from reset release.
        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].j, tbl[i].a, tbl[i].h, tbl[i].k);
            chk($sformatf("v%0d_req", i), 32'(fetch_req_out), 32'(tbl[i].st != 3'd0));
            chk($sformatf("v%0d_pc", i), pc_out, tbl[i].pc);
            chk($sformatf("v%0d_hold", i), 32'(hold_flag_out), 32'(tbl[i].hf));
            chk($sformatf("v%0d_flush_if_id", i), 32'(flush_if_id_out), 32'(tbl[i].fi));
            chk($sformatf("v%0d_flush_id_ex", i), 32'(flush_id_ex_out), 32'(tbl[i].fe));
            chk($sformatf("v%0d_state", i), 32'(state_out), 32'(tbl[i].st));
`ifdef CTRL_PERF_CNT_EN
            chk($sformatf("v%0d_perf_cycle", i), perf_cycle_out, e_cyc);
            chk($sformatf("v%0d_perf_stall", i), perf_stall_out, e_stl);
            chk($sformatf("v%0d_perf_flush", i), perf_flush_out, e_fls);
`endif
            $display("vec %0d j=%0d a=%h h=%0d k=%0d -> pc=%h hold=%b st=%0d",
                     i, tbl[i].j, tbl[i].a, tbl[i].h, tbl[i].k, pc_out, hold_flag_out, state_out);
            next_edge();
        end

        // Fetch stall, then asynchronous reset in the middle of it.
        apply(0, 0, 0, 0);
        check_model(100);
        next_edge();
        apply(0, 0, 0, 0);
        check_model(101);
        #2;
        rst = 1'b0;
        #1;
        check_reset_vals("async_rst");
        $display("async reset mid-stall -> pc=%h hold=%b st=%0d", pc_out, hold_flag_out, state_out);
        next_edge();
        next_edge();
        model_reset();
        rst = 1'b1;

        // Randomized traffic against the reference model.
        for (int n = 0; n < 400; n++) begin
            apply(($urandom_range(0, 7) == 0), $urandom,
                  ($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
            check_model(n);
            next_edge();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
